mem_access_unit: RTL and testbench

MEM-stage memory access unit: consumes the EX/MEM pipeline register fields, performs load/store transactions to data memory over a request/acknowledge handshake, and produces the MEM/WB fields. Aligns store data, generates byte enables, extracts and sign/zero-extends load data, and stalls the upstream pipeline while a memory transaction is outstanding. Also resolves the branch decision from the EX/MEM branch and zero flags.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: access-size codes, FSM states,
// byte-enable patterns and the alignment rule.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mau_state_t;

    // Stores only know sb/sh as narrow accesses; every other code is a word.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a,
                                        input logic store);
        logic ok;
        ok = (a == 2'b00);
        if (store) begin
            if (f3 == F3_SB)      ok = 1'b1;
            else if (f3 == F3_SH) ok = ~a[0];
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU)      ok = 1'b1;
            else if (f3 == F3_LH || f3 == F3_LHU) ok = ~a[0];
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to the access code.
module lsu_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [31:0] w_shifted;
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_result = w_shifted;
        case (i_funct3)
            F3_LB:   o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_result = {24'h0, w_shifted[7:0]};
            F3_LHU:  o_result = {16'h0, w_shifted[15:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues one data-memory transaction at a time over req/ack, stalls the
// front of the pipeline while it is outstanding, and fills the MEM/WB register.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic              Branch_i,
    input  logic              Zero_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       ALUResult_i,
    input  logic [31:0]       rdata2_i,
    input  logic [31:0]       addr_jump_i,
    input  logic [4:0]        rd_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              stall_o,
    output logic              pc_src_o,
    output logic [31:0]       pc_target_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [31:0]       mem_rdata_o,
    output logic [31:0]       ALUResult_o,
    output logic [4:0]        rd_o,
    output logic              misalign_o
);

    mau_state_t        r_state;
    logic              r_req, r_we, r_regwrite, r_memtoreg, r_misalign;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_load_data, r_mem_rdata, r_alu;
    logic [3:0]        r_be;
    logic [4:0]        r_rd;

    logic        w_mem_op, w_is_load, w_aligned, w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_fmt;

    assign w_mem_op  = MemRead_i | MemWrite_i;
    assign w_is_load = MemRead_i & ~MemWrite_i;
    assign w_aligned = is_aligned(funct3_i, ALUResult_i[1:0], MemWrite_i);
    // Reset masks the stall so the pipeline is never frozen while being cleared.
    assign w_stall   = ~rst_n & ((r_state == S_IDLE & w_mem_op & w_aligned) | (r_state == S_WAIT));

    always_comb begin
        w_be    = BE_WORD;
        w_wdata = rdata2_i;
        case (funct3_i)
            F3_SB: begin
                w_be    = BE_BYTE << ALUResult_i[1:0];
                w_wdata = {4{rdata2_i[7:0]}};
            end
            F3_SH: begin
                w_be    = BE_HALF << {ALUResult_i[1], 1'b0};
                w_wdata = {2{rdata2_i[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_load_align (
        .i_rdata   (dmem_rdata_i),
        .i_addr_lo (ALUResult_i[1:0]),
        .i_funct3  (funct3_i),
        .o_result  (w_load_fmt)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_load_data <= '0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_mem_rdata <= '0;
            r_alu       <= '0;
            r_rd        <= '0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_mem_op && w_aligned) begin
                    r_req   <= 1'b1;
                    r_we    <= MemWrite_i;
                    r_addr  <= {ALUResult_i[ADDR_W-1:2], 2'b00};
                    r_wdata <= w_wdata;
                    r_be    <= w_be;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (dmem_ack_i) begin
                    r_req       <= 1'b0;
                    r_load_data <= w_load_fmt;
                    r_state     <= S_DONE;
                end
                // EX/MEM still shows the finished instruction here; it must not restart.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (!w_stall) begin
                r_regwrite  <= RegWrite_i & ~(w_mem_op & ~w_aligned);
                r_memtoreg  <= MemtoReg_i;
                r_alu       <= ALUResult_i;
                r_rd        <= rd_i;
                r_misalign  <= w_mem_op & ~w_aligned;
                r_mem_rdata <= (r_state == S_DONE && w_is_load) ? r_load_data : 32'h0;
            end else begin
                r_regwrite  <= 1'b0;
                r_memtoreg  <= 1'b0;
                r_alu       <= '0;
                r_rd        <= '0;
                r_misalign  <= 1'b0;
                r_mem_rdata <= '0;
            end
        end
    end

    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_wdata_o = r_wdata;
    assign dmem_be_o    = r_be;
    assign stall_o      = w_stall;
    assign pc_src_o     = Branch_i & Zero_i;
    assign pc_target_o  = addr_jump_i;
    assign RegWrite_o   = r_regwrite;
    assign MemtoReg_o   = r_memtoreg;
    assign mem_rdata_o  = r_mem_rdata;
    assign ALUResult_o  = r_alu;
    assign rd_o         = r_rd;
    assign misalign_o   = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table run back-to-back against a
// small ack-latency memory responder, plus reset and branch sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i, Zero_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUResult_i, rdata2_i, addr_jump_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        stall_o, pc_src_o;
    logic [31:0] pc_target_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] mem_rdata_o, ALUResult_o;
    logic [4:0]  rd_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .MemtoReg_i(MemtoReg_i), .Branch_i(Branch_i), .Zero_i(Zero_i),
        .funct3_i(funct3_i), .ALUResult_i(ALUResult_i), .rdata2_i(rdata2_i),
        .addr_jump_i(addr_jump_i), .rd_i(rd_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .stall_o(stall_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .mem_rdata_o(mem_rdata_o), .ALUResult_o(ALUResult_o),
        .rd_o(rd_o), .misalign_o(misalign_o)
    );

    typedef struct {
        string       name;
        logic        rw, mr, mw, m2r;
        logic [2:0]  f3;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        int          k;
        logic [31:0] rdata;
        int          e_stalls;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rw;
        logic [31:0] e_rdata;
        logic        e_mis;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  stalls = 0;
        int  reqs = 0;
        bit  done = 0;
        bit  s;
        RegWrite_i  = v.rw;  MemRead_i = v.mr; MemWrite_i = v.mw; MemtoReg_i = v.m2r;
        funct3_i    = v.f3;  ALUResult_i = v.alu; rdata2_i = v.rs2; rd_i = v.rd;
        for (int c = 0; c < 30 && !done; c++) begin
            #1;
            s = stall_o;
            if (dmem_req_o) begin
                chk({v.name, " we"}, {31'h0, dmem_we_o}, {31'h0, v.e_we});
                chk({v.name, " addr"}, dmem_addr_o, v.e_addr);
                if (v.e_we) begin
                    chk({v.name, " be"}, {28'h0, dmem_be_o}, {28'h0, v.e_be});
                    chk({v.name, " wdata"}, dmem_wdata_o, v.e_wdata);
                end
                dmem_ack_i   = (reqs == v.k);
                dmem_rdata_i = (reqs == v.k) ? v.rdata : 32'h0BAD0BAD;
                reqs++;
            end else begin
                dmem_ack_i = 1'b0;
            end
            if (s) stalls++;
            @(posedge clk);
            #1;
            dmem_ack_i = 1'b0;
            if (s) begin
                chk({v.name, " bubble"}, {25'h0, RegWrite_o, misalign_o, rd_o},
                    32'h0);
            end else begin
                done = 1;
                chk({v.name, " RegWrite_o"}, {31'h0, RegWrite_o}, {31'h0, v.e_rw});
                chk({v.name, " MemtoReg_o"}, {31'h0, MemtoReg_o}, {31'h0, v.m2r});
                chk({v.name, " rd_o"}, {27'h0, rd_o}, {27'h0, v.rd});
                chk({v.name, " ALUResult_o"}, ALUResult_o, v.alu);
                chk({v.name, " mem_rdata_o"}, mem_rdata_o, v.e_rdata);
                chk({v.name, " misalign_o"}, {31'h0, misalign_o}, {31'h0, v.e_mis});
            end
            @(negedge clk);
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s timeout waiting for stall_o to drop", v.name);
        end
        chk({v.name, " stall_cycles"}, stalls, v.e_stalls);
        chk({v.name, " req_seen"}, {31'h0, reqs != 0}, {31'h0, v.e_req});
        $display("vec %-10s stalls=%0d reqs=%0d rdata=%h rw=%0b mis=%0b", v.name, stalls, reqs,
                 mem_rdata_o, RegWrite_o, misalign_o);
    endtask

    initial begin
        //           name        rw mr mw m2r f3      alu           rs2           rd  k rdata         st req we addr          be     wdata         erw erdata        mis
        vecs[0]  = '{"lw_k0",    1, 1, 0, 1, 3'b010, 32'h00000100, 32'h0,        5,  0, 32'hDEADBEEF, 2, 1, 0, 32'h00000100, 4'hF, 32'h0,        1, 32'hDEADBEEF, 0};
        vecs[1]  = '{"add",      1, 0, 0, 0, 3'b000, 32'h00000055, 32'h0,        7,  0, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        1, 32'h00000000, 0};
        vecs[2]  = '{"lb_k2",    1, 1, 0, 1, 3'b000, 32'h00000103, 32'h0,        3,  2, 32'h80FF0000, 4, 1, 0, 32'h00000100, 4'h0, 32'h0,        1, 32'hFFFFFF80, 0};
        vecs[3]  = '{"lbu_k2",   1, 1, 0, 1, 3'b100, 32'h00000103, 32'h0,        4,  2, 32'h80FF0000, 4, 1, 0, 32'h00000100, 4'h0, 32'h0,        1, 32'h00000080, 0};
        vecs[4]  = '{"sh_22",    0, 0, 1, 0, 3'b001, 32'h00000022, 32'h1234ABCD, 0,  1, 32'h0,        3, 1, 1, 32'h00000020, 4'hC, 32'hABCDABCD, 0, 32'h00000000, 0};
        vecs[5]  = '{"lw_mis",   1, 1, 0, 1, 3'b010, 32'h00000101, 32'h0,        6,  0, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h00000000, 1};
        vecs[6]  = '{"lh_102",   1, 1, 0, 1, 3'b001, 32'h00000102, 32'h0,        8,  1, 32'h80011234, 3, 1, 0, 32'h00000100, 4'h0, 32'h0,        1, 32'hFFFF8001, 0};
        vecs[7]  = '{"lhu_102",  1, 1, 0, 1, 3'b101, 32'h00000102, 32'h0,        9,  0, 32'h80011234, 2, 1, 0, 32'h00000100, 4'h0, 32'h0,        1, 32'h00008001, 0};
        vecs[8]  = '{"sb_101",   0, 0, 1, 0, 3'b000, 32'h00000101, 32'h000000A5, 0,  0, 32'h0,        2, 1, 1, 32'h00000100, 4'h2, 32'hA5A5A5A5, 0, 32'h00000000, 0};
        vecs[9]  = '{"sw_k3",    0, 0, 1, 0, 3'b010, 32'h00000204, 32'hCAFEF00D, 0,  3, 32'h0,        5, 1, 1, 32'h00000204, 4'hF, 32'hCAFEF00D, 0, 32'h00000000, 0};
        vecs[10] = '{"lh_mis",   1, 1, 0, 1, 3'b001, 32'h00000101, 32'h0,        10, 0, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h00000000, 1};
        vecs[11] = '{"rdwr_st",  0, 1, 1, 0, 3'b010, 32'h00000300, 32'h01020304, 0,  0, 32'h11111111, 2, 1, 1, 32'h00000300, 4'hF, 32'h01020304, 0, 32'h00000000, 0};
        vecs[12] = '{"f3_011",   1, 1, 0, 1, 3'b011, 32'h00000010, 32'h0,        11, 1, 32'h89ABCDEF, 3, 1, 0, 32'h00000010, 4'h0, 32'h0,        1, 32'h89ABCDEF, 0};
        vecs[13] = '{"lb_101",   1, 1, 0, 1, 3'b000, 32'h00000101, 32'h0,        12, 0, 32'h0000C300, 2, 1, 0, 32'h00000100, 4'h0, 32'h0,        1, 32'hFFFFFFC3, 0};

        rst_n = 1'b1;
        RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0;
        Branch_i = 0; Zero_i = 0; funct3_i = 0; ALUResult_i = 0; rdata2_i = 0;
        addr_jump_i = 0; rd_i = 0; dmem_rdata_i = 0; dmem_ack_i = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset req", {31'h0, dmem_req_o}, 32'h0);
        chk("reset stall", {31'h0, stall_o}, 32'h0);
        chk("reset memwb", {RegWrite_o, MemtoReg_o, misalign_o, dmem_we_o, dmem_be_o, rd_o, 17'h0}, 32'h0);
        chk("reset alu", ALUResult_o | mem_rdata_o | dmem_addr_o | dmem_wdata_o, 32'h0);
        $display("reset: req=%0b stall=%0b", dmem_req_o, stall_o);
        @(negedge clk);
        rst_n = 1'b0;

        Branch_i = 1; Zero_i = 1; addr_jump_i = 32'h12345678;
        #1;
        chk("branch pc_src", {31'h0, pc_src_o}, 32'h1);
        chk("branch target", pc_target_o, 32'h12345678);
        $display("branch taken: pc_src=%0b target=%h", pc_src_o, pc_target_o);
        Zero_i = 0;
        #1;
        chk("branch not taken", {31'h0, pc_src_o}, 32'h0);
        $display("branch not taken: pc_src=%0b", pc_src_o);
        Branch_i = 0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset while a load is waiting for its ack.
        RegWrite_i = 1; MemRead_i = 1; MemWrite_i = 0; MemtoReg_i = 1;
        funct3_i = 3'b010; ALUResult_i = 32'h400; rd_i = 5'd9;
        @(posedge clk);
        #1;
        chk("midwait req_up", {31'h0, dmem_req_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midwait req_drop", {31'h0, dmem_req_o}, 32'h0);
        chk("midwait stall", {31'h0, stall_o}, 32'h0);
        chk("midwait memwb", {25'h0, RegWrite_o, MemtoReg_o, rd_o}, 32'h0);
        $display("reset mid-wait: req=%0b stall=%0b rw=%0b", dmem_req_o, stall_o, RegWrite_o);
        @(negedge clk);
        rst_n = 1'b0;
        RegWrite_i = 0; MemRead_i = 0; MemtoReg_i = 0; rd_i = 0;
        run_vec(vecs[1]);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
